cla_seq_ctrl: RTL and testbench
===============================

# cla_seq_ctrl

Multi-cycle sequencer that computes a WIDTH-bit sum using one shared GROUPSIZE-bit carry-lookahead group slice. Each cycle it feeds one chunk of the latched operands to the slice. It chains the carry from the slice's group generate/propagate outputs and assembles the result. It sits between the execute-stage issue logic and the group CLA slice, and trades latency for area in the ALU add path.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of GROUPSIZE
- GROUPSIZE, 4, width of the shared group slice; CHUNKS = WIDTH/GROUPSIZE, CHUNKS ≥ 2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at clk edge
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of the MSB chunk
- out_zero  out  1  out_sum == 0
- grp_a  out  GROUPSIZE  chunk of A driven to the slice
- grp_b  out  GROUPSIZE  chunk of B driven to the slice
- grp_cin  out  1  carry into the slice
- grp_s  in  GROUPSIZE  slice sum, combinational from grp_a/grp_b/grp_cin
- grp_gp  in  2  slice [1]=group generate, [0]=group propagate

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On accept: latch in_a/in_b into op registers, carry←in_cin, idx←0, go to RUN.
- RUN
  - Drive grp_a=op_a[idx*GROUPSIZE +: GROUPSIZE], grp_b likewise, grp_cin=carry.
  - At the edge: sum_reg chunk idx←grp_s, carry←grp_gp[1] | (grp_gp[0] & carry), idx←idx+1.
  - When idx==CHUNKS-1, go to DONE.
- DONE
  - out_valid=1.
  - out_sum=sum_reg, out_cout=carry, out_zero=(sum_reg==0).
  - On out_ready, leave DONE.
  - in_ready=out_ready in DONE. If in_valid is also high, accept the new op and go straight to RUN; otherwise go to IDLE.
- Outside RUN, grp_a, grp_b and grp_cin are driven 0.
- idx width is $clog2(CHUNKS); idx wraps to 0 only via a new accept.
- in_a, in_b and in_cin are ignored outside the accept cycle. Operands are held internally, so the requester may change them freely after the accept.
- out_sum, out_cout and out_zero hold stable for as long as out_valid=1 and out_ready=0.

## Timing
- Reset (async assert) values:
  - state=IDLE, idx=0, carry=0, sum_reg=0.
  - out_valid=0, out_cout=0, out_zero=0 (forced low during reset), grp_*=0.
  - in_ready is forced 0 while rst is high and reads 1 in the first cycle after deassert.
- Reset mid-RUN or mid-DONE aborts the operation. The result is discarded and no out_valid is produced.
- Latency: accept at edge T0; out_valid high from edge T0+CHUNKS (8 cycles at defaults).
- Throughput with out_ready held 1 and in_valid held 1: one result per CHUNKS+1 cycles (RUN×CHUNKS, DONE×1, with the next op accepted in that DONE cycle).
- The slice path is combinational: grp_* out → slice → grp_s/grp_gp in → registers, all within one cycle.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - Adds an input port in_sub (1 bit), latched at accept.
  - When in_sub=1: op_b←~in_b and carry←1 (in_cin is ignored). out_cout=1 means no borrow.
- CLA_SEQ_SUB_EN undefined: no in_sub port; add only.

## Test plan
Defaults throughout (WIDTH=32, GROUPSIZE=4), with the team group CLA slice attached.
- a=0xFFFFFFFF, b=0x1, cin=0 → out_sum=0x00000000, out_cout=1, out_zero=1; out_valid rises exactly 8 cycles after the accept edge.
- a=0x12345678, b=0x0FEDCBA8, cin=0 → 0x22222220, cout=0. Repeat with cin=1 → 0x22222221.
- Backpressure: complete an op, hold out_ready=0 for 5 cycles → out_valid, out_sum and out_cout stay stable; in_ready=0; grp_a/grp_b/grp_cin=0.
- Back-to-back: in_valid and out_ready held 1 with two ops queued → the second op is accepted in the DONE cycle of the first; results are 9 cycles apart.
- Assert rst for 1 cycle after 3 RUN cycles → state IDLE and out_valid stays 0. Then accept a=1, b=2 → 0x00000003 after 8 cycles.
- With CLA_SEQ_SUB_EN, in_sub=1:
  - a=5, b=7 → 0xFFFFFFFE, cout=0.
  - a=7, b=5 → 0x00000002, cout=1.

Source files
------------

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: multi-cycle WIDTH-bit adder over one shared CLA group slice; CLA_SEQ_SUB_EN adds in_sub (a-b)
module cla_seq_ctrl #(
    parameter int WIDTH     = 32,
    parameter int GROUPSIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                 in_sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_cout,
    output logic                 out_zero,
    output logic [GROUPSIZE-1:0] grp_a,
    output logic [GROUPSIZE-1:0] grp_b,
    output logic                 grp_cin,
    input  logic [GROUPSIZE-1:0] grp_s,
    input  logic [1:0]           grp_gp
);
    localparam int CHUNKS = WIDTH / GROUPSIZE;
    localparam int IW     = $clog2(CHUNKS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx;
    logic              carry, accept, last, sub;
    logic [WIDTH-1:0]  op_a, op_b, sum_reg;

`ifdef CLA_SEQ_SUB_EN
    assign sub = in_sub;
`else
    assign sub = 1'b0;
`endif

    assign last   = idx == IW'(CHUNKS - 1);
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
        state_nx = accept                      ? RUN  :
                   (state == RUN && last)      ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            carry   <= 1'b0;
            sum_reg <= '0;
            op_a    <= '0;
            op_b    <= '0;
        end else if (accept) begin
            op_a  <= in_a;
            op_b  <= sub ? ~in_b : in_b;
            carry <= sub | in_cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_reg[idx*GROUPSIZE +: GROUPSIZE] <= grp_s;
            carry <= grp_gp[1] | (grp_gp[0] & carry);
            idx   <= last ? idx : idx + 1'b1;
        end
    end

    assign out_valid = state == DONE;
    assign out_sum   = sum_reg;
    assign out_cout  = out_valid & carry;
    assign out_zero  = out_valid & ~|sum_reg;
    assign grp_a     = state == RUN ? op_a[idx*GROUPSIZE +: GROUPSIZE] : '0;
    assign grp_b     = state == RUN ? op_b[idx*GROUPSIZE +: GROUPSIZE] : '0;
    assign grp_cin   = state == RUN && carry;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: scoreboard bench with a behavioural group slice and an arithmetic reference model
module tb_cla_seq_ctrl;
    localparam int W = 32;
    localparam int G = 4;
    localparam int CHUNKS = W / G;

    logic         clk = 0, rst = 1;
    logic         in_valid = 0, in_ready, in_cin = 0;
    logic [W-1:0] in_a = 0, in_b = 0;
    logic         out_valid, out_ready = 1, out_cout, out_zero;
    logic [W-1:0] out_sum;
    logic [G-1:0] grp_a, grp_b, grp_s;
    logic         grp_cin;
    logic [1:0]   grp_gp;
`ifdef CLA_SEQ_SUB_EN
    logic         in_sub = 0;
`endif

    cla_seq_ctrl #(.WIDTH(W), .GROUPSIZE(G)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CLA_SEQ_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_zero(out_zero),
        .grp_a(grp_a), .grp_b(grp_b), .grp_cin(grp_cin),
        .grp_s(grp_s), .grp_gp(grp_gp)
    );

    always #5 clk = ~clk;

    // Behavioural group slice: sum plus group generate/propagate from plain addition
    logic [G:0] slice_full, slice_ab;
    assign slice_full = {1'b0, grp_a} + {1'b0, grp_b} + (G+1)'(grp_cin);
    assign slice_ab   = {1'b0, grp_a} + {1'b0, grp_b};
    assign grp_s      = slice_full[G-1:0];
    assign grp_gp     = {slice_ab[G], slice_ab == (G+1)'((1 << G) - 1)};

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   rise_q[$];
    int   tests = 0, fails = 0, cyc = 0;
    logic rand_rdy = 0;
    logic prev_v = 0, prev_r = 0, prev_c = 0;
    logic [W-1:0] prev_sum = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        logic [W:0] t;
        if (sub) begin
            e.sum  = a - b;
            e.cout = a >= b;
        end else begin
            t      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            e.sum  = t[W-1:0];
            e.cout = t[W];
        end
        e.zero = e.sum == 0;
        return e;
    endfunction

    // Monitor: latency, hold-stability, idle slice drive and scoreboard pops
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 0;
        end else begin
            if (out_valid) begin
                if (!prev_v) begin
                    rise_q.push_back(cyc);
                    if (acc_q.size() > 0) chk("latency", 64'(cyc - acc_q.pop_front()), CHUNKS);
                    else chk("spurious_valid", out_valid, 0);
                end
                if (prev_v && !prev_r) begin
                    chk("hold_sum", out_sum, prev_sum);
                    chk("hold_cout", out_cout, prev_c);
                end
                if (!out_ready) begin
                    chk("busy_in_ready", in_ready, 0);
                    chk("done_grp_zero", {grp_a, grp_b, grp_cin}, 0);
                end else if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum", out_sum, e.sum);
                    chk("cout", out_cout, e.cout);
                    chk("zero", out_zero, e.zero);
                end else begin
                    chk("unexpected_result", out_valid, 0);
                end
            end
            prev_v   = out_valid;
            prev_r   = out_ready;
            prev_sum = out_sum;
            prev_c   = out_cout;
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic keep);
        int n = 0;
        in_a = a; in_b = b; in_cin = cin;
`ifdef CLA_SEQ_SUB_EN
        in_sub = sub;
`endif
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
`ifdef CLA_SEQ_SUB_EN
        exp_q.push_back(model(a, b, cin, sub));
`else
        exp_q.push_back(model(a, b, cin, 1'b0));
`endif
        acc_q.push_back(cyc);
        if (!keep) in_valid = 0;
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_grp", {grp_a, grp_b, grp_cin}, 0);
        @(posedge clk);
        #1 rst = 0;
        #1 chk("ready_after_rst", in_ready, 1);

        issue(32'hFFFF_FFFF, 32'h1, 0, 0, 0);
        drain();
        issue(32'h1234_5678, 32'h0FED_CBA8, 0, 0, 0);
        issue(32'h1234_5678, 32'h0FED_CBA8, 1, 0, 0);
        drain();

        out_ready = 0;
        issue($urandom, $urandom, 0, 0, 0);
        repeat (CHUNKS + 5) @(posedge clk);
        #1 out_ready = 1;
        drain();

        rise_q.delete();
        issue(32'hDEAD_BEEF, 32'h0101_0101, 0, 0, 1);
        issue(32'h8000_0000, 32'h8000_0000, 1, 0, 0);
        drain();
        if (rise_q.size() == 2) chk("b2b_spacing", 64'(rise_q[1] - rise_q[0]), CHUNKS + 1);
        else chk("b2b_results", 64'(rise_q.size()), 2);

        issue(32'hAAAA_AAAA, 32'h5555_5555, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_grp", {grp_a, grp_b, grp_cin}, 0);
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        issue(32'h1, 32'h2, 0, 0, 0);
        drain();

`ifdef CLA_SEQ_SUB_EN
        issue(32'd5, 32'd7, 0, 1, 0);
        issue(32'd7, 32'd5, 0, 1, 0);
        issue(32'd9, 32'd9, 0, 1, 0);
        drain();
`endif

        rand_rdy = 1;
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] a, b;
            logic c, s;
            a = $urandom; b = $urandom; c = 1'($urandom);
            s = 0;
`ifdef CLA_SEQ_SUB_EN
            s = 1'($urandom);
`endif
            if (i % 6 == 0) b = ~a;
            if (i % 7 == 0) a = 0;
            issue(a, b, c, s, 0);
        end
        drain();
        rand_rdy = 0;
        #1 out_ready = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, fails);
        $fatal(1);
    end
endmodule
